// File: rtl/flexpipe_pkg.sv
// Shared types for the flexpipe compute-core stub: channel and buffer-flip
// state encodings plus the completed-job counter width.
package flexpipe_pkg;
  localparam int STUB_JOBS_W = 32;

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_e;

  typedef enum logic [2:0] {F_IDLE, F_DRAIN, F_WAIT, F_ACK, F_HOLD} flip_state_e;
endpackage

// File: rtl/flexpipe_stub_core_if.sv
// Job/flip handshake bundle between the harness (master) and the stub core (slave).
interface flexpipe_stub_core_if import flexpipe_pkg::*; #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int CYC_W  = 64
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                   job_valid;
  logic                   job_ready;
  logic [CH_W-1:0]        job_ch;
  logic [CNT_W-1:0]       job_cycles;
  logic [NUM_CH-1:0]      busy;
  logic [NUM_CH-1:0]      done_pulse;
  logic [CYC_W-1:0]       compute_cycles_done;
  logic [STUB_JOBS_W-1:0] jobs_done;
  logic                   flip_req;
  logic                   flip_ack;

  modport master (
    output job_valid, job_ch, job_cycles, flip_req,
    input  job_ready, busy, done_pulse, compute_cycles_done, jobs_done, flip_ack
  );

  modport slave (
    input  job_valid, job_ch, job_cycles, flip_req,
    output job_ready, busy, done_pulse, compute_cycles_done, jobs_done, flip_ack
  );
endinterface

// File: rtl/flexpipe_stub_channel.sv
// One stub compute channel: IDLE/RUN FSM that burns max(cycles,1) cycles per job.
module flexpipe_stub_channel import flexpipe_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles,
  output logic             busy,
  output logic             done_pulse
);
  ch_state_e        st;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= CH_IDLE;
      cnt        <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (st)
        CH_IDLE: if (start) begin
          st  <= CH_RUN;
          cnt <= (cycles == '0) ? CNT_W'(1) : cycles;
        end
        CH_RUN: begin
          // done lands in the first idle cycle, i.e. as busy falls
          if (cnt == CNT_W'(1)) begin
            st         <= CH_IDLE;
            done_pulse <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: st <= CH_IDLE;
      endcase
    end
  end

  assign busy = (st == CH_RUN);
endmodule

// File: rtl/flexpipe_stub_core.sv
// Multi-channel compute-core stand-in: per-channel job timers, aggregate counters,
// and a drain-then-acknowledge buffer flip handshake.
module flexpipe_stub_core import flexpipe_pkg::*; #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int CYC_W   = 64,
  parameter int ACK_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  flexpipe_stub_core_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WAIT_W = (ACK_LAT > 1) ? $clog2(ACK_LAT) : 1;

  logic [NUM_CH-1:0]      busy, done, start;
  logic                   ready_en, ch_idle_sel, job_ready, accept;
  logic [STUB_JOBS_W-1:0] done_cnt;
  logic [CYC_W-1:0]       cyc_cnt;
  logic [STUB_JOBS_W-1:0] jobs_cnt;
  flip_state_e            fstate;
  logic [WAIT_W-1:0]      wcnt;
  logic                   flip_ack;

  // Out-of-range channel codes match no channel, so they never look idle.
  always_comb begin
    ch_idle_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.job_ch == CH_W'(i)) ch_idle_sel = !busy[i];
  end

  assign job_ready = ready_en && ch_idle_sel && (fstate == F_IDLE) && !bus.flip_req;
  assign accept    = bus.job_valid && job_ready;

  always_comb begin
    start    = '0;
    done_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      start[i] = accept && (bus.job_ch == CH_W'(i));
      done_cnt = done_cnt + STUB_JOBS_W'(done[i]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    flexpipe_stub_channel #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[g]),
      .cycles     (bus.job_cycles),
      .busy       (busy[g]),
      .done_pulse (done[g])
    );
  end

  // ready_en keeps job_ready low while reset is held and for the first cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      cyc_cnt  <= '0;
      jobs_cnt <= '0;
    end else begin
      ready_en <= 1'b1;
      if (|busy) cyc_cnt <= cyc_cnt + CYC_W'(1);
      jobs_cnt <= jobs_cnt + done_cnt;
    end
  end

  // Ack appears ACK_LAT cycles after the first DRAIN cycle that sees all channels idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate   <= F_IDLE;
      wcnt     <= '0;
      flip_ack <= 1'b0;
    end else begin
      flip_ack <= 1'b0;
      case (fstate)
        F_IDLE: if (bus.flip_req) fstate <= F_DRAIN;
        F_DRAIN: begin
          if (!bus.flip_req) fstate <= F_IDLE;
          else if (busy == '0) begin
            wcnt <= WAIT_W'(ACK_LAT - 1);
            if (ACK_LAT == 1) begin
              fstate   <= F_ACK;
              flip_ack <= 1'b1;
            end else begin
              fstate <= F_WAIT;
            end
          end
        end
        F_WAIT: begin
          if (!bus.flip_req) fstate <= F_IDLE;
          else if (wcnt == WAIT_W'(1)) begin
            fstate   <= F_ACK;
            flip_ack <= 1'b1;
          end else begin
            wcnt <= wcnt - WAIT_W'(1);
          end
        end
        F_ACK:  fstate <= F_HOLD;
        F_HOLD: if (!bus.flip_req) fstate <= F_IDLE;
        default: fstate <= F_IDLE;
      endcase
    end
  end

  assign bus.job_ready           = job_ready;
  assign bus.busy                = busy;
  assign bus.done_pulse          = done;
  assign bus.compute_cycles_done = cyc_cnt;
  assign bus.jobs_done           = jobs_cnt;
  assign bus.flip_ack            = flip_ack;
endmodule

// File: tb/tb_flexpipe_stub_core.sv
// Bench for flexpipe_stub_core: directed vector table, hand-written flip/reset
// sequences, then random traffic, all checked every cycle against a timestamp model.
module tb_flexpipe_stub_core;
  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 16;
  localparam int CYC_W   = 64;
  localparam int ACK_LAT = 2;
  localparam int CH_W    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flexpipe_stub_core_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CYC_W(CYC_W)) bus ();

  flexpipe_stub_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CYC_W(CYC_W), .ACK_LAT(ACK_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: remaining busy cycles per channel, done flags, counters, and flip
  // request bookkeeping by cycle timestamps.
  int              rem[NUM_CH];
  bit              mdone[NUM_CH];
  longint unsigned m_ccd;
  int unsigned     m_jd;
  bit              m_rdy_en;
  bit              f_eng, f_acked;
  int              f_idle_at;

  int busy_any_cnt, done_cnt, ack_cnt, last_busy_cyc, ack_cyc;

  typedef struct {
    int ch;
    int cycles;
    bit exp_ready;
    int exp_busy;
    int exp_done;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      rem[i]   = 0;
      mdone[i] = 1'b0;
    end
    m_ccd     = 0;
    m_jd      = 0;
    m_rdy_en  = 1'b0;
    f_eng     = 1'b0;
    f_acked   = 1'b0;
    f_idle_at = -1;
  endfunction

  function automatic bit m_ready();
    if (!m_rdy_en || f_eng || bus.flip_req) return 1'b0;
    if (int'(bus.job_ch) >= NUM_CH) return 1'b0;
    return rem[int'(bus.job_ch)] == 0;
  endfunction

  function automatic bit m_ack();
    return f_eng && !f_acked && (f_idle_at >= 0) && (cyc == f_idle_at + ACK_LAT);
  endfunction

  function automatic void model_step();
    bit acc, any, ack_now;
    int pc;
    acc     = bus.job_valid && m_ready();
    ack_now = m_ack();
    any     = 1'b0;
    pc      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rem[i] > 0) any = 1'b1;
      pc += int'(mdone[i]);
    end
    if (any) m_ccd++;
    m_jd += pc;
    for (int i = 0; i < NUM_CH; i++) begin
      mdone[i] = (rem[i] == 1);
      if (rem[i] > 0) rem[i]--;
    end
    if (acc) rem[int'(bus.job_ch)] = (bus.job_cycles == '0) ? 1 : int'(bus.job_cycles);
    if (!f_eng) begin
      if (bus.flip_req) begin
        f_eng     = 1'b1;
        f_acked   = 1'b0;
        f_idle_at = -1;
      end
    end else if (ack_now) f_acked = 1'b1;
    else if (!bus.flip_req) f_eng = 1'b0;
    else if (!f_acked && f_idle_at < 0 && !any) f_idle_at = cyc;
    m_rdy_en = 1'b1;
  endfunction

  task automatic drive(input int v, input int ch, input int cy, input int fr);
    bus.job_valid  = (v != 0);
    bus.job_ch     = CH_W'(ch);
    bus.job_cycles = CNT_W'(cy);
    bus.flip_req   = (fr != 0);
  endtask

  // Called just after a negedge with inputs set; checks, clocks the model, returns at next negedge.
  task automatic tick();
    logic [NUM_CH-1:0] eb, ed;
    if (!rst_n) model_reset();
    #2;
    for (int i = 0; i < NUM_CH; i++) begin
      eb[i] = rem[i] > 0;
      ed[i] = mdone[i];
    end
    chk("busy", bus.busy, eb);
    chk("done_pulse", bus.done_pulse, ed);
    chk("compute_cycles_done", bus.compute_cycles_done, m_ccd);
    chk("jobs_done", bus.jobs_done, m_jd);
    chk("flip_ack", bus.flip_ack, m_ack());
    chk("job_ready", bus.job_ready, m_ready());
    if (|bus.busy) begin
      busy_any_cnt++;
      last_busy_cyc = cyc;
    end
    done_cnt += $countones(bus.done_pulse);
    if (bus.flip_ack) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    longint unsigned base_ccd;
    int unsigned base_jd;
    bit fr;

    vt[0] = '{0, 5, 1'b1, 5, 1};
    vt[1] = '{1, 0, 1'b1, 1, 1};
    vt[2] = '{NUM_CH, 7, 1'b0, 0, 0};
    vt[3] = '{2, 1, 1'b1, 1, 1};
    vt[4] = '{1, 3, 1'b1, 3, 1};
    vt[5] = '{2, 12, 1'b1, 12, 1};

    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // T1: reset lands in the middle of a 10-cycle job
    drive(1, 0, 10, 0); tick();
    drive(0, 0, 0, 0);  repeat (3) tick();
    rst_n = 1'b0; tick();
    chk("t1_busy_in_rst", bus.busy, 0);
    chk("t1_ccd_in_rst", bus.compute_cycles_done, 0);
    chk("t1_ready_in_rst", bus.job_ready, 0);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (12) tick();
    chk("t1_no_done_after_rst", done_cnt, 0);
    chk("t1_ready_after_rst", bus.job_ready, 1);
    chk("t1_ccd_after_rst", bus.compute_cycles_done, 0);
    chk("t1_jobs_after_rst", bus.jobs_done, 0);

    // T2/T4 and friends: single jobs from idle
    foreach (vt[k]) begin
      base_ccd = m_ccd;
      base_jd  = m_jd;
      busy_any_cnt = 0;
      done_cnt = 0;
      drive(1, vt[k].ch, vt[k].cycles, 0);
      #1 chk("vec_ready", bus.job_ready, vt[k].exp_ready);
      tick();
      drive(0, 0, 0, 0);
      repeat (16) tick();
      chk("vec_busy_cycles", busy_any_cnt, vt[k].exp_busy);
      chk("vec_done_count", done_cnt, vt[k].exp_done);
      chk("vec_ccd_delta", bus.compute_cycles_done, base_ccd + longint'(vt[k].exp_busy));
      chk("vec_jobs_delta", bus.jobs_done, base_jd + vt[k].exp_done);
    end

    // T3: overlapping jobs on consecutive cycles, retry on a busy channel
    base_ccd = m_ccd;
    base_jd  = m_jd;
    busy_any_cnt = 0;
    drive(1, 1, 3, 0); tick();
    drive(1, 0, 6, 0); tick();
    drive(1, 0, 4, 0);
    #1 chk("t3_retry_ready", bus.job_ready, 0);
    tick();
    drive(0, 0, 0, 0); repeat (12) tick();
    chk("t3_ccd", bus.compute_cycles_done, base_ccd + 64'd7);
    chk("t3_jobs", bus.jobs_done, base_jd + 32'd2);
    chk("t3_busy_union", busy_any_cnt, 7);

    // T5: flip while ch1 runs; ack once, no re-ack while held
    drive(1, 1, 8, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(1, 0, 5, 1);
    #1 chk("t5_ready_on_req", bus.job_ready, 0);
    ack_cnt = 0;
    for (int n = 0; n < 40 && ack_cnt == 0; n++) tick();
    chk("t5_ack_seen", ack_cnt, 1);
    chk("t5_ack_latency", ack_cyc - last_busy_cyc, ACK_LAT + 1);
    repeat (6) tick();
    chk("t5_single_ack", ack_cnt, 1);
    drive(1, 0, 5, 0);
    #1 chk("t5_ready_in_hold", bus.job_ready, 0);
    tick();
    chk("t5_ready_after_drop", bus.job_ready, 1);
    tick();
    drive(0, 0, 0, 0); repeat (8) tick();

    // T6: one-cycle flip pulse while ch0 busy aborts without an ack
    drive(1, 0, 6, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    ack_cnt = 0;
    repeat (10) tick();
    chk("t6_no_ack", ack_cnt, 0);
    drive(1, 0, 2, 0);
    #1 chk("t6_ready_again", bus.job_ready, 1);
    tick();
    drive(0, 0, 0, 0); repeat (4) tick();

    // random traffic with occasional flips and resets
    fr = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) fr = !fr;
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, NUM_CH)),
            int'($urandom_range(0, 12)), int'(fr));
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
